mem_stage: RTL and testbench

- Memory-access stage sitting directly downstream of the execute stage.
- Consumes execute results (load/store enables, address, store data, ALU result, destination register).
- Runs a req/ack transaction with the data memory for loads and stores, and stalls upstream while a transaction is in flight.
- Presents registered write-back data to the register-file write stage.

---
 rtl/mem_stage.sv | 142 ++++++++++++++
 tb/tb_mem_stage.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory-access stage: forwards ALU results or performs one data-memory req/ack access per
// instruction, stalling upstream while busy. Optional macro: MEM_MISALIGN_CHECK_EN.
module mem_stage #(
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_in_valid,
    output logic        o_in_ready,
    input  logic        i_write_reg,
    input  logic        i_load_en,
    input  logic        i_store_en,
    input  logic [4:0]  i_rd,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic [31:0] i_res,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [31:0] o_dmem_addr,
    output logic [31:0] o_dmem_wdata,
    input  logic        i_dmem_ack,
    input  logic [31:0] i_dmem_rdata,
    output logic        o_wb_valid,
    output logic        o_wb_en,
    output logic [4:0]  o_wb_rd,
    output logic [31:0] o_wb_data,
    output logic        o_bus_err,
    output logic        o_stall
);

    typedef enum logic {StIdle, StAccess} state_e;

    state_e            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic              r_write_reg;
    logic [4:0]        r_rd;
    logic [31:0]       r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_res;
    logic              r_wb_valid;
    logic              r_wb_en;
    logic [4:0]        r_wb_rd;
    logic [31:0]       r_wb_data;
    logic              r_bus_err;

    logic              w_accept;
    logic              w_mem;
    logic              w_misalign;
    logic              w_req;

    assign w_accept = i_in_valid && (r_state == StIdle);
    assign w_mem    = i_load_en || i_store_en;

`ifdef MEM_MISALIGN_CHECK_EN
    assign w_misalign = |i_addr[1:0];
`else
    assign w_misalign = 1'b0;
`endif

    // Request is decoded straight from state so an async reset drops it without a clock.
    assign w_req        = (r_state == StAccess);
    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_req && r_we;
    assign o_dmem_addr  = w_req ? r_addr  : 32'd0;
    assign o_dmem_wdata = w_req ? r_wdata : 32'd0;

    assign o_in_ready = (r_state == StIdle);
    assign o_stall    = (r_state != StIdle);
    assign o_wb_valid = r_wb_valid;
    assign o_wb_en    = r_wb_en;
    assign o_wb_rd    = r_wb_rd;
    assign o_wb_data  = r_wb_data;
    assign o_bus_err  = r_bus_err;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_write_reg <= 1'b0;
            r_rd        <= 5'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_res       <= 32'd0;
            r_wb_valid  <= 1'b0;
            r_wb_en     <= 1'b0;
            r_wb_rd     <= 5'd0;
            r_wb_data   <= 32'd0;
            r_bus_err   <= 1'b0;
        end else begin
            r_wb_valid <= 1'b0;
            r_wb_en    <= 1'b0;
            r_wb_rd    <= 5'd0;
            r_wb_data  <= 32'd0;
            r_bus_err  <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        // Load wins when both enables are set.
                        r_we        <= i_store_en && !i_load_en;
                        r_write_reg <= i_write_reg;
                        r_rd        <= i_rd;
                        r_addr      <= i_addr;
                        r_wdata     <= i_data;
                        r_res       <= i_res;
                        r_cnt       <= '0;
                        if (!w_mem) begin
                            r_wb_valid <= 1'b1;
                            r_wb_en    <= i_write_reg && (i_rd != 5'd0);
                            r_wb_rd    <= i_rd;
                            r_wb_data  <= i_res;
                        end else if (w_misalign) begin
                            r_wb_valid <= 1'b1;
                            r_bus_err  <= 1'b1;
                        end else begin
                            r_state <= StAccess;
                        end
                    end
                end
                StAccess: begin
                    if (i_dmem_ack) begin
                        r_state    <= StIdle;
                        r_wb_valid <= 1'b1;
                        r_wb_rd    <= r_rd;
                        r_wb_en    <= !r_we && (r_rd != 5'd0);
                        r_wb_data  <= r_we ? 32'd0 : i_dmem_rdata;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        r_state    <= StIdle;
                        r_wb_valid <= 1'b1;
                        r_bus_err  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage against a transaction-level scoreboard.
module tb_mem_stage;

    localparam int unsigned TO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_in_valid, i_write_reg, i_load_en, i_store_en, i_dmem_ack;
    logic [4:0]  i_rd;
    logic [31:0] i_addr, i_data, i_res, i_dmem_rdata;
    logic        o_in_ready, o_dmem_req, o_dmem_we, o_wb_valid, o_wb_en, o_bus_err, o_stall;
    logic [4:0]  o_wb_rd;
    logic [31:0] o_dmem_addr, o_dmem_wdata, o_wb_data;

    mem_stage #(.TIMEOUT(TO), .CNT_W(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_in_valid(i_in_valid), .o_in_ready(o_in_ready),
        .i_write_reg(i_write_reg), .i_load_en(i_load_en), .i_store_en(i_store_en),
        .i_rd(i_rd), .i_addr(i_addr), .i_data(i_data), .i_res(i_res),
        .o_dmem_req(o_dmem_req), .o_dmem_we(o_dmem_we), .o_dmem_addr(o_dmem_addr),
        .o_dmem_wdata(o_dmem_wdata), .i_dmem_ack(i_dmem_ack), .i_dmem_rdata(i_dmem_rdata),
        .o_wb_valid(o_wb_valid), .o_wb_en(o_wb_en), .o_wb_rd(o_wb_rd), .o_wb_data(o_wb_data),
        .o_bus_err(o_bus_err), .o_stall(o_stall)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cycle;
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
        logic        err;
    } wb_t;

    wb_t exp_q[$];
    int  n_checks = 0;
    int  n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Every cycle the write-back port must match the scoreboard: a pulse only when due.
    always @(negedge clk) begin : monitor
        wb_t e;
        if (exp_q.size() > 0 && exp_q[0].cycle == cyc) begin
            e = exp_q.pop_front();
            check("wb_valid", 32'(o_wb_valid), 32'd1);
            check("bus_err", 32'(o_bus_err), 32'(e.err));
            check("wb_en", 32'(o_wb_en), 32'(e.en));
            if (e.en) check("wb_rd", 32'(o_wb_rd), 32'(e.rd));
            if (!e.err) check("wb_data", o_wb_data, e.data);
        end else begin
            check("wb_idle_valid", 32'(o_wb_valid), 32'd0);
            check("wb_idle_err", 32'(o_bus_err), 32'd0);
            check("wb_idle_en", 32'(o_wb_en), 32'd0);
        end
    end

    // Called at a negedge while idle; leaves in_valid high so calls can be chained.
    task automatic nonmem(input logic wr, input logic [4:0] rd, input logic [31:0] res);
        check("nm_in_ready", 32'(o_in_ready), 32'd1);
        i_in_valid  = 1'b1;
        i_write_reg = wr;
        i_load_en   = 1'b0;
        i_store_en  = 1'b0;
        i_rd        = rd;
        i_res       = res;
        i_addr      = $urandom;
        i_data      = $urandom;
        i_dmem_ack  = 1'($urandom_range(0, 1));
        exp_q.push_back('{cycle: cyc + 1, en: wr && (rd != 5'd0), rd: rd, data: res,
                          err: 1'b0});
        @(negedge clk);
    endtask

    // d = cycles of req before ack; d >= TO means memory never answers.
    task automatic memop(input logic ld, input logic st, input logic [31:0] addr,
                         input logic [31:0] data, input logic [4:0] rd,
                         input logic [31:0] rdata, input int unsigned d, input logic stray);
        logic is_store;
        logic mis;
        is_store = st && !ld;
`ifdef MEM_MISALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`else
        mis = 1'b0;
`endif
        check("mem_in_ready", 32'(o_in_ready), 32'd1);
        i_in_valid  = 1'b1;
        i_load_en   = ld;
        i_store_en  = st;
        i_addr      = addr;
        i_data      = data;
        i_rd        = rd;
        i_write_reg = 1'($urandom_range(0, 1));
        i_res       = $urandom;
        i_dmem_ack  = 1'b0;
        if (mis) exp_q.push_back('{cycle: cyc + 1, en: 1'b0, rd: 5'd0, data: 32'd0, err: 1'b1});
        @(negedge clk);
        i_in_valid = 1'b0;
        if (mis) begin
            check("mis_no_req", 32'(o_dmem_req), 32'd0);
            return;
        end
        for (int i = 0; i < int'(TO); i++) begin
            check("req_high", 32'(o_dmem_req), 32'd1);
            check("stall", 32'(o_stall), 32'd1);
            check("in_ready_low", 32'(o_in_ready), 32'd0);
            check("dmem_addr", o_dmem_addr, addr);
            check("dmem_we", 32'(o_dmem_we), 32'(is_store));
            if (is_store) check("dmem_wdata", o_dmem_wdata, data);
            if (stray) begin
                // Offered while busy; must not be taken.
                i_in_valid  = 1'($urandom_range(0, 1));
                i_load_en   = 1'b0;
                i_store_en  = 1'b0;
                i_write_reg = 1'b1;
                i_rd        = 5'd9;
            end
            if (i == int'(d)) begin
                i_dmem_ack   = 1'b1;
                i_dmem_rdata = rdata;
                exp_q.push_back('{cycle: cyc + 1, en: !is_store && (rd != 5'd0), rd: rd,
                                  data: is_store ? 32'd0 : rdata, err: 1'b0});
                @(negedge clk);
                i_dmem_ack   = 1'b0;
                i_dmem_rdata = $urandom;
                i_in_valid   = 1'b0;
                check("req_drop_ack", 32'(o_dmem_req), 32'd0);
                return;
            end
            if (i == int'(TO) - 1)
                exp_q.push_back('{cycle: cyc + 1, en: 1'b0, rd: 5'd0, data: 32'd0, err: 1'b1});
            i_dmem_rdata = $urandom;
            @(negedge clk);
        end
        i_in_valid = 1'b0;
        check("req_drop_to", 32'(o_dmem_req), 32'd0);
        check("ready_after_to", 32'(o_in_ready), 32'd1);
    endtask

    task automatic idle_cycle();
        i_in_valid = 1'b0;
        i_dmem_ack = 1'($urandom_range(0, 1));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a;
        int unsigned k;
        rst_n = 1'b0;
        i_in_valid = 0; i_write_reg = 0; i_load_en = 0; i_store_en = 0; i_dmem_ack = 0;
        i_rd = 0; i_addr = 0; i_data = 0; i_res = 0; i_dmem_rdata = 0;
        #12;
        check("rst_in_ready", 32'(o_in_ready), 32'd1);
        check("rst_stall", 32'(o_stall), 32'd0);
        check("rst_req", 32'(o_dmem_req), 32'd0);
        check("rst_wb_valid", 32'(o_wb_valid), 32'd0);
        check("rst_bus_err", 32'(o_bus_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        nonmem(1'b1, 5'd5, 32'h1234);
        i_in_valid = 1'b0;
        @(negedge clk);
        memop(1'b1, 1'b0, 32'h100, 32'h0, 5'd7, 32'hDEADBEEF, 2, 1'b0);
        memop(1'b0, 1'b1, 32'h40, 32'hA5A5A5A5, 5'd3, 32'h0, 0, 1'b0);
        memop(1'b1, 1'b0, 32'h200, 32'h0, 5'd4, 32'h0, TO + 1, 1'b0);
        memop(1'b1, 1'b1, 32'h80, 32'h55, 5'd6, 32'h600DF00D, 1, 1'b1);
        memop(1'b1, 1'b0, 32'h104, 32'h0, 5'd0, 32'hCAFEF00D, 0, 1'b0);
        memop(1'b1, 1'b0, 32'h102, 32'h0, 5'd8, 32'h13579BDF, 1, 1'b0);
        nonmem(1'b1, 5'd0, 32'hFFFF);
        for (int i = 1; i < 6; i++) nonmem(1'b1, 5'(i), 32'(i * 17));
        memop(1'b0, 1'b1, 32'hC0, 32'h1, 5'd2, 32'h0, TO - 1, 1'b1);
        idle_cycle();
        idle_cycle();

        // Reset while a load is in flight, then a late ack must be ignored.
        i_in_valid = 1'b1; i_load_en = 1'b1; i_store_en = 1'b0; i_addr = 32'h300; i_rd = 5'd11;
        @(negedge clk);
        i_in_valid = 1'b0;
        check("pre_rst_req", 32'(o_dmem_req), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_req_drop", 32'(o_dmem_req), 32'd0);
        check("async_in_ready", 32'(o_in_ready), 32'd1);
        check("async_stall", 32'(o_stall), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        i_dmem_ack = 1'b1;
        i_dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        @(negedge clk);
        i_dmem_ack = 1'b0;
        check("post_rst_ready", 32'(o_in_ready), 32'd1);

        for (int n = 0; n < 300; n++) begin
            k = $urandom_range(0, 9);
            if (k < 4) begin
                nonmem(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
            end else if (k < 9) begin
                a = $urandom;
                if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
                case ($urandom_range(0, 2))
                    0: memop(1'b1, 1'b0, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
                             $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
                    1: memop(1'b0, 1'b1, a, $urandom, 5'($urandom_range(0, 31)), $urandom,
                             $urandom_range(0, TO + 1), 1'($urandom_range(0, 1)));
                    default: memop(1'b1, 1'b1, a, $urandom, 5'($urandom_range(0, 31)),
                                   $urandom, $urandom_range(0, TO + 1),
                                   1'($urandom_range(0, 1)));
                endcase
            end else begin
                idle_cycle();
            end
        end
        i_in_valid = 1'b0;
        i_dmem_ack = 1'b0;
        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
